// File: rtl/delay_mon_pkg.sv
// Shared types and default constants for the DELAY pulse monitor.
// Used by delay_interval_cnt and delay_monitor.
package delay_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam int N_DEF        = 1250;
    localparam int CBITS_DEF    = 11;
    localparam int TOL_DEF      = 2;
    localparam int LOCK_CNT_DEF = 3;

endpackage

// File: rtl/delay_interval_cnt.sv
// Saturating cycle counter between pulses, with interval decodes
// (early / good / timeout) relative to the nominal N+1 period.
module delay_interval_cnt
    import delay_mon_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CBITS = CBITS_DEF,
    parameter int TOL   = TOL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    output logic [CBITS-1:0] cnt,
    output logic [CBITS-1:0] ivl,
    output logic             early,
    output logic             good,
    output logic             timeout
);

    localparam logic [CBITS:0]   LO = (CBITS+1)'(N + 1 - TOL);
    localparam logic [CBITS:0]   HI = (CBITS+1)'(N + 1 + TOL);
    localparam logic [CBITS-1:0] TO = CBITS'(N + TOL);

    logic [CBITS:0] ival;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pulse) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // One extra bit so cnt+1 at all-ones cannot wrap into the good window
    assign ival    = {1'b0, cnt} + (CBITS+1)'(1);
    assign ivl     = ival[CBITS-1:0];
    assign early   = pulse && (ival < LO);
    assign good    = pulse && (ival >= LO) && (ival <= HI);
    assign timeout = !pulse && (cnt == TO);

endmodule

// File: rtl/delay_monitor.sv
// Lock/err/late monitor for the periodic DELAY pulse.
// Define DELAY_MON_STATS_EN to add the saturating err_cnt output.
module delay_monitor
    import delay_mon_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int CBITS    = CBITS_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             locked,
    output logic             err,
    output logic             late,
    output logic [CBITS-1:0] period
`ifdef DELAY_MON_STATS_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int GBITS = $clog2(LOCK_CNT + 1);
    localparam logic [GBITS-1:0] LC = GBITS'(LOCK_CNT);

    state_t             state;
    logic [GBITS-1:0]   gcnt;
    logic [GBITS-1:0]   gnext;
    logic [CBITS-1:0]   cnt;
    logic [CBITS-1:0]   ivl;
    logic               early;
    logic               good;
    logic               timeout;

    delay_interval_cnt #(
        .N     (N),
        .CBITS (CBITS),
        .TOL   (TOL)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse   (sig_in),
        .cnt     (cnt),
        .ivl     (ivl),
        .early   (early),
        .good    (good),
        .timeout (timeout)
    );

    assign gnext = gcnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gcnt   <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
            late   <= 1'b0;
            period <= '0;
        end else begin
            err  <= 1'b0;
            late <= 1'b0;
            unique case (state)
                IDLE: begin
                    // First pulse only sets the reference point
                    if (sig_in) begin
                        state <= ACQUIRE;
                        gcnt  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (good) begin
                        period <= ivl;
                        gcnt   <= gnext;
                        if (gnext == LC) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (early) begin
                        period <= ivl;
                        gcnt   <= '0;
                    end else if (timeout) begin
                        state <= IDLE;
                        late  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        period <= ivl;
                    end else if (early) begin
                        period <= ivl;
                        state  <= ACQUIRE;
                        gcnt   <= '0;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        err    <= 1'b1;
                        late   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAY_MON_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_delay_monitor.sv
// Scoreboard bench for delay_monitor: timestamp-based reference model
// plus directed lock / tolerance / timeout / stuck-high / reset scenarios.
module tb_delay_monitor;
    import delay_mon_pkg::*;

    localparam int N  = 1250;
    localparam int TL = 2;
    localparam int LO = N + 1 - TL;
    localparam int HI = N + 1 + TL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic        locked;
    logic        err;
    logic        late;
    logic [10:0] period;
`ifdef DELAY_MON_STATS_EN
    logic [15:0] err_cnt;
`endif

    delay_monitor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .locked  (locked),
        .err     (err),
        .late    (late),
        .period  (period)
`ifdef DELAY_MON_STATS_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        err;
        logic        late;
        logic [10:0] period;
        logic [15:0] ecnt;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     seen_err = 0;
    int     seen_late = 0;

    int     ms;
    int     mg;
    longint mcyc;
    longint mlast;
    logic [10:0] mper;
    logic [15:0] mec;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ms    = 0;
        mg    = 0;
        mcyc  = 0;
        mlast = 0;
        mper  = '0;
        mec   = '0;
        q.delete();
    endtask

    // Interval = cycles since the last sampled pulse
    task automatic model_step(input logic s);
        exp_t   e;
        longint iv;
        iv = mcyc - mlast;
        e.err  = 1'b0;
        e.late = 1'b0;
        case (ms)
            0: if (s) begin
                ms = 1;
                mg = 0;
            end
            1: if (s) begin
                mper = 11'(iv);
                if (iv >= LO && iv <= HI) begin
                    mg++;
                    if (mg == 3) ms = 2;
                end else begin
                    mg = 0;
                end
            end else if (iv == HI) begin
                ms = 0;
                e.late = 1'b1;
            end
            default: if (s) begin
                mper = 11'(iv);
                if (iv < LO) begin
                    ms = 1;
                    mg = 0;
                    e.err = 1'b1;
                end
            end else if (iv == HI) begin
                ms = 0;
                e.err = 1'b1;
                e.late = 1'b1;
            end
        endcase
        if (e.err && mec != 16'hffff) mec++;
        if (s) mlast = mcyc;
        mcyc++;
        e.locked = (ms == 2);
        e.period = mper;
        e.ecnt   = mec;
        q.push_back(e);
    endtask

    task automatic cyc(input logic s);
        exp_t e;
        sig_in = s;
        model_step(s);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("locked", locked, e.locked);
            chk("err", err, e.err);
            chk("late", late, e.late);
            chk("period", period, e.period);
`ifdef DELAY_MON_STATS_EN
            chk("err_cnt", err_cnt, e.ecnt);
`endif
        end
        seen_err  += int'(err);
        seen_late += int'(late);
    endtask

    task automatic send(input int iv);
        repeat (iv - 1) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic do_reset();
        sig_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_late", late, 0);
        chk("rst_period", period, 0);
`ifdef DELAY_MON_STATS_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic lock_up(input int first);
        send(first);
        repeat (3) send(N + 1);
    endtask

    initial begin
        int e0;
        int l0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        repeat (10) cyc(1'b0);

        // Lock from reset: 4 pulses
        send(5);
        repeat (2) send(N + 1);
        chk("pre_lock", locked, 0);
        send(N + 1);
        chk("lock1", locked, 1);
        chk("period1", period, N + 1);
        chk("noerr1", seen_err, 0);

        // Early pulse while locked, then relock
        send(1000);
        chk("early_err", err, 1);
        chk("early_unlock", locked, 0);
        chk("early_period", period, 1000);
        repeat (3) send(N + 1);
        chk("relock2", locked, 1);

        // Tolerance edges
        e0 = seen_err;
        send(LO);
        send(HI);
        chk("tol_edges_locked", locked, 1);
        chk("tol_edges_noerr", seen_err - e0, 0);
        send(LO - 1);
        chk("tol_lo_err", err, 1);
        repeat (3) send(N + 1);
        chk("relock4", locked, 1);
        e0 = seen_err;
        l0 = seen_late;
        send(HI + 1);
        chk("tol_hi_err", seen_err - e0, 1);
        chk("tol_hi_late", seen_late - l0, 1);
        repeat (3) send(N + 1);
        chk("relock4b", locked, 1);

        // Pulse stops: timeout at cnt == N+TOL
        repeat (HI - 1) cyc(1'b0);
        chk("pre_timeout", err, 0);
        cyc(1'b0);
        chk("timeout_err", err, 1);
        chk("timeout_late", late, 1);
        chk("timeout_unlock", locked, 0);
        cyc(1'b0);
        chk("timeout_err_1cyc", err, 0);
        chk("timeout_late_1cyc", late, 0);

        // Stuck-high input while locked
        lock_up(7);
        chk("relock5", locked, 1);
        repeat (N) cyc(1'b0);
        e0 = seen_err;
        repeat (10) cyc(1'b1);
        chk("stuck_one_err", seen_err - e0, 1);
        chk("stuck_period", period, 1);
        chk("stuck_unlocked", locked, 0);
        repeat (HI + 5) cyc(1'b0);
        chk("stuck_never_lock", locked, 0);

        // Async reset mid-operation
        lock_up(3);
        chk("relock6", locked, 1);
        repeat (20) cyc(1'b0);
        do_reset();
        send(9);
        repeat (2) send(N + 1);
        chk("post_rst_3p", locked, 0);
        send(N + 1);
        chk("post_rst_4p", locked, 1);
        repeat (4) cyc(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
